// File: rtl/cluster_clock_phase_gen_if.sv
// Ratio-update handshake between the cluster control registers and the phase generator.
interface cluster_clock_phase_gen_if #(
  parameter int DIV_W = 8
);
  logic [DIV_W-1:0] div_i;
  logic             div_valid_i;
  logic             div_ready_o;
  logic [DIV_W-1:0] div_cur_o;

  modport master (output div_i, div_valid_i, input div_ready_o, div_cur_o);
  modport slave  (input div_i, div_valid_i, output div_ready_o, div_cur_o);
endinterface

// File: rtl/cluster_clock_phase_gen.sv
// Integer divider producing two phase signals whose XOR is clk_i/N at 50 % duty;
// phase0 lives on the rising edge, phase1 on the falling edge.
module cluster_clock_phase_gen #(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clk_en_i,
  cluster_clock_phase_gen_if.slave  ctrl,
  output logic                      phase0_o,
  output logic                      phase1_o
);

  localparam logic [DIV_W-1:0] L_DIV_RST = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0] L_ONE     = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_cur;
  logic [DIV_W-1:0] r_pend;
  logic             r_pend_vld;
  logic             r_ready;
  logic             r_applied;
  logic             r_phase0;
  logic             r_phase1;

  logic [DIV_W-1:0] w_half;
  logic [DIV_W-1:0] w_last;
  logic [DIV_W-1:0] w_cnt_inc;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_div_req;
  logic             w_odd;
  logic             w_boundary;
  logic             w_wrap;
  logic             w_apply;
  logic             w_xfer;
  logic             w_tog0;
  logic             w_tog1;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_cnt_nxt  = r_cnt;
    w_half     = r_div_cur >> 1;
    w_odd      = r_div_cur[0];
    w_last     = r_div_cur - L_ONE;
    w_cnt_inc  = r_cnt + L_ONE;
    w_boundary = (r_cnt == w_last);
    w_wrap     = w_boundary & clk_en_i;
    w_apply    = w_wrap & r_pend_vld;
    w_xfer     = ctrl.div_valid_i & r_ready;
    w_div_req  = (ctrl.div_i == '0) ? L_ONE : ctrl.div_i;

    if (w_wrap)           w_cnt_nxt = '0;
    else if (!w_boundary) w_cnt_nxt = w_cnt_inc;

    w_tog0 = w_wrap | (~w_odd & ~w_boundary & (w_cnt_inc == w_half));
    // Guarding on the XOR being high keeps a held N=1 counter (cnt == H == 0) from pulsing.
    w_tog1 = w_odd & (r_cnt == w_half) & (r_phase0 ^ r_phase1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt      <= L_DIV_RST - L_ONE;
      r_div_cur  <= L_DIV_RST;
      r_pend     <= L_DIV_RST;
      r_pend_vld <= 1'b0;
      r_ready    <= 1'b1;
      r_applied  <= 1'b0;
      r_phase0   <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_applied <= w_apply;
      if (w_tog0) r_phase0 <= ~r_phase0;
      if (w_apply) r_div_cur <= r_pend;

      if (w_xfer) begin
        r_pend     <= w_div_req;
        r_pend_vld <= 1'b1;
      end else if (w_apply) begin
        r_pend_vld <= 1'b0;
      end

      if (w_xfer)         r_ready <= 1'b0;
      else if (r_applied) r_ready <= 1'b1;
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_phase1 <= 1'b0;
    else if (w_tog1) r_phase1 <= ~r_phase1;
  end

  assign phase0_o         = r_phase0;
  assign phase1_o         = r_phase1;
  assign ctrl.div_ready_o = r_ready;
  assign ctrl.div_cur_o   = r_div_cur;

endmodule

// File: tb/tb_cluster_clock_phase_gen.sv
// Scoreboarded bench: ratio transfers push expectations that are popped when div_cur_o
// changes; XOR pulse shapes are measured in half-cycle samples.
module tb_cluster_clock_phase_gen;

  logic clk_i;
  logic rst_ni;
  logic clk_en_i;
  logic phase0_o;
  logic phase1_o;
  logic w_xor;

  cluster_clock_phase_gen_if #(.DIV_W(8)) dif ();

  cluster_clock_phase_gen #(.DIV_W(8), .DIV_RESET(1)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clk_en_i (clk_en_i),
    .ctrl     (dif.slave),
    .phase0_o (phase0_o),
    .phase1_o (phase1_o)
  );

  assign w_xor = phase0_o ^ phase1_o;

  typedef struct {
    logic [7:0] ratio;
    int         cyc;
    int         max_lat;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         cur_n = 1;
  logic [7:0] last_cur = 8'd1;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: every change of the ratio in force must match the oldest transfer.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      last_cur = dif.div_cur_o;
    end else if (dif.div_cur_o !== last_cur) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cur_change", dif.div_cur_o, last_cur);
      end else begin
        mon_e = exp_q.pop_front();
        check("apply_value", dif.div_cur_o, mon_e.ratio);
        check("apply_latency_ok", (cyc - mon_e.cyc) <= mon_e.max_lat, 1);
      end
      last_cur = dif.div_cur_o;
    end
  end

  task automatic xfer(input logic [7:0] val);
    int n = 0;
    @(negedge clk_i);
    while (!dif.div_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("xfer_ready_wait", n < 50, 1);
    dif.div_i       = val;
    dif.div_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    dif.div_valid_i = 1'b0;
    exp_q.push_back('{ratio: (val == 8'd0) ? 8'd1 : val, cyc: cyc, max_lat: cur_n + 1});
    check("ready_drop", dif.div_ready_o, 0);
  endtask

  task automatic wait_apply(input logic [7:0] exp_n);
    int n = 0;
    while (dif.div_cur_o !== exp_n && n < 50) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check("apply_seen", dif.div_cur_o, exp_n);
    cur_n = int'(exp_n);
  endtask

  // Skips the pulse in progress, then measures the next one in half-cycle samples.
  task automatic meas(input string tag, input int exp_hi, input int exp_lo, input int exp_tog);
    int   n = 0;
    int   hi = 0;
    int   lo = 0;
    int   tog = 0;
    logic p1;
    while (w_xor && n < 200) begin @(clk_i); #1; n++; end
    while (!w_xor && n < 200) begin @(clk_i); #1; n++; end
    check({tag, "_rise_found"}, n < 200, 1);
    check({tag, "_rise_on_posedge"}, clk_i, 1);
    p1 = phase1_o;
    while (w_xor && n < 400) begin
      hi++;
      @(clk_i); #1; n++;
      if (phase1_o !== p1) begin tog++; p1 = phase1_o; end
    end
    while (!w_xor && n < 400) begin
      lo++;
      @(clk_i); #1; n++;
      if (phase1_o !== p1) begin tog++; p1 = phase1_o; end
    end
    check({tag, "_high_halves"}, hi, exp_hi);
    check({tag, "_low_halves"}, lo, exp_lo);
    check({tag, "_phase1_toggles"}, tog, exp_tog);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int lo;
    int n;
    rst_ni          = 1'b1;
    clk_en_i        = 1'b1;
    dif.div_i       = 8'd0;
    dif.div_valid_i = 1'b0;
    #1 rst_ni = 1'b0;

    // Reset state and N = 1 pass-through.
    #11;
    check("rst_phase0", phase0_o, 0);
    check("rst_phase1", phase1_o, 0);
    check("rst_div_cur", dif.div_cur_o, 1);
    check("rst_ready", dif.div_ready_o, 1);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("first_rise", w_xor, 1);
    for (int i = 0; i < 6; i++) begin
      @(clk_i); #1;
      check("n1_copy", w_xor, clk_i);
    end

    // N = 4: even ratio, phase1 idle, ready low until one cycle after apply.
    xfer(8'd4);
    wait_apply(8'd4);
    check("n4_ready_at_apply", dif.div_ready_o, 0);
    check("n4_first_high", w_xor, 1);
    @(posedge clk_i); #1;
    check("n4_ready_back", dif.div_ready_o, 1);
    meas("n4", 4, 4, 0);
    meas("n4b", 4, 4, 0);

    // N = 3: odd ratio, falling edge on clk negedge.
    xfer(8'd3);
    wait_apply(8'd3);
    meas("n3", 3, 3, 1);
    meas("n3b", 3, 3, 1);

    // div_i = 0 maps to 1; a request while not ready is ignored.
    xfer(8'd0);
    dif.div_i       = 8'd9;
    dif.div_valid_i = 1'b1;
    check("ready_low_ignore", dif.div_ready_o, 0);
    @(posedge clk_i); #1;
    dif.div_valid_i = 1'b0;
    wait_apply(8'd1);
    meas("n0", 1, 1, 1);
    repeat (10) @(posedge clk_i);
    #1;
    check("ignored_req_ready", dif.div_ready_o, 1);
    check("ignored_req_cur", dif.div_cur_o, 1);

    // N = 5 with clk_en dropped mid-period.
    xfer(8'd5);
    wait_apply(8'd5);
    check("n5_start", w_xor, 1);
    clk_en_i = 1'b0;
    hi = 1;
    n  = 0;
    do begin
      @(clk_i); #1; n++;
      if (w_xor) hi++;
    end while (w_xor && n < 40);
    check("gate_finish_high", hi, 5);
    lo = 0;
    for (int i = 0; i < 20; i++) begin
      @(clk_i); #1;
      if (!w_xor) lo++;
    end
    check("gate_held_low", lo, 20);
    check("gate_cnt_hold", dut.r_cnt, 4);
    @(negedge clk_i); #1;
    clk_en_i = 1'b1;
    @(posedge clk_i); #1;
    check("gate_restart", w_xor, 1);
    hi = 1;
    n  = 0;
    do begin
      @(clk_i); #1; n++;
      if (w_xor) hi++;
    end while (w_xor && n < 40);
    check("restart_high", hi, 5);
    lo = 1;
    n  = 0;
    do begin
      @(clk_i); #1; n++;
      if (!w_xor) lo++;
    end while (!w_xor && n < 40);
    check("restart_low", lo, 5);

    // Reset with an update pending: pending ratio must never appear.
    xfer(8'd7);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_phase0", phase0_o, 0);
    check("midrst_phase1", phase1_o, 0);
    check("midrst_div_cur", dif.div_cur_o, 1);
    check("midrst_ready", dif.div_ready_o, 1);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #2;
    rst_ni = 1'b1;
    cur_n  = 1;
    repeat (20) @(posedge clk_i);
    #1;
    check("no_stale_apply", dif.div_cur_o, 1);
    check("post_rst_ready", dif.div_ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      @(clk_i); #1;
      check("post_rst_copy", w_xor, clk_i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cluster_clock_phase_gen.md
# cluster_clock_phase_gen

Programmable integer clock divider that drives the two inputs of the cluster clock XOR2 cell. It produces two phase signals. `phase0_o` toggles only on rising edges of `clk_i` and `phase1_o` toggles only on falling edges, so the downstream XOR yields `clk_i / N` with exactly 50 % duty for every N ≥ 1, including odd ratios. It sits in the cluster clock tree ahead of the XOR2 cell and takes ratio updates from the cluster control registers over a valid/ready handshake.

## Interface
- `DIV_W`, default 8: width of the division ratio.
- `DIV_RESET`, default 1: ratio in force after reset; must be in 1 .. 2^DIV_W−1.
- `clk_i`  in  1  source clock. Both edges are used; this is the only clock.
- `rst_ni`  in  1  asynchronous, active-low reset. Applies to all flops, posedge and negedge.
- `clk_en_i`  in  1  output-clock enable; gating takes effect only at period boundaries.
- `div_i`  in  DIV_W  requested ratio N. A value of 0 is treated as 1.
- `div_valid_i`  in  1  ratio update request.
- `div_ready_o`  out  1  update can be accepted.
- `div_cur_o`  out  DIV_W  ratio currently in force.
- `phase0_o`  out  1  rising-edge phase; drives XOR input A.
- `phase1_o`  out  1  falling-edge phase; drives XOR input B/S.

## Operation
- Reset values:
  - `cnt` = DIV_RESET−1.
  - `div_cur_o` = DIV_RESET.
  - pending register is empty.
  - `div_ready_o` = 1.
  - `phase0_o` = `phase1_o` = 0.
  - The XOR output is therefore 0.
- Counter `cnt` (DIV_W bits) runs on posedge. Its next value is 0 when `cnt == N−1`; otherwise it is `cnt+1`.
- Let H = `N >> 1`. This single compare value covers both cases: N/2 for even N and (N−1)/2 for odd N.
- Posedge logic:
  - `phase0_o` toggles when the new `cnt` is 0.
  - For even N, `phase0_o` also toggles when the new `cnt` equals H.
- Negedge logic:
  - For odd N only, `phase1_o` toggles on the falling edge while `cnt == H`.
  - For even N, `phase1_o` holds.
- Resulting XOR output:
  - Goes high at the posedge where `cnt` becomes 0.
  - Goes low after N/2 cycles: at a posedge for even N, at a negedge for odd N.
  - N = 1 gives a delayed copy of `clk_i`.
- Both phase registers are plain flops with no combinational path to the outputs. Outputs must be glitch-free.
- Period boundary: a posedge at which `cnt == N−1` and the counter would wrap. The XOR output is low here.
- Clock gating:
  - If `clk_en_i` = 0 at a boundary, `cnt` holds at N−1 and neither phase toggles. The XOR output stays low.
  - Gating resumes at the first posedge at which `clk_en_i` = 1.
  - Deasserting `clk_en_i` mid-period has no effect until the boundary; the current period always completes.
- Ratio update:
  - A transfer occurs on a posedge with `div_valid_i & div_ready_o`.
  - On transfer, `div_i` (0 mapped to 1) is stored in the pending register and `div_ready_o` drops the next cycle.
  - The pending value is applied at the next boundary at which the counter wraps, i.e. not while gated. At that edge `div_cur_o` takes the new value, `cnt` goes to 0, and the new period uses the new N and H.
  - `div_ready_o` rises one cycle after the apply edge.
  - While `div_ready_o` = 0, `div_valid_i` is ignored.
- Phase parity is not reset on ratio change. The XOR output stays low at the boundary, so no short pulse or glitch occurs across a change.
- Reset mid-operation forces the reset values immediately. The XOR output drops to 0 asynchronously, and any pending update is lost.

## Timing
- Latency from the first posedge after reset release to the first XOR rising edge: 1 cycle, i.e. that posedge itself when `clk_en_i` = 1 and DIV_RESET = 1. In general the counter wraps on the first enabled posedge.
- The new ratio takes effect at most (N_old + 1) cycles after the transfer, and only once gating permits.
- The phase outputs have posedge- or negedge-to-output delay only. The XOR skew budget is owned by the clock-tree constraints.
- `div_cur_o` changes only at apply edges.

## Test plan
- Reset with DIV_RESET = 1 and `clk_en_i` = 1 -> XOR(phase0, phase1) follows `clk_i` one edge late; `div_cur_o` = 1, `div_ready_o` = 1.
- Transfer N = 4 -> XOR period is 4 cycles, high for 2 cycles starting at a posedge; `phase1_o` stays constant; `div_ready_o` is low until one cycle after the boundary.
- Transfer N = 3 -> XOR is high for 1.5 cycles and low for 1.5 cycles; the falling edge coincides with a `clk_i` negedge and `phase1_o` toggles once per period.
- Transfer `div_i` = 0 -> `div_cur_o` = 1 and behaviour matches N = 1; a second `div_valid_i` asserted while ready is low is ignored.
- With N = 5, drop `clk_en_i` mid-period -> the current period completes, the output then stays low with `cnt` held at 4; raising `clk_en_i` restarts the output on the next posedge with no runt pulse.
- Assert `rst_ni` low mid-period with an update pending -> phases are 0 immediately, `div_cur_o` = DIV_RESET, `div_ready_o` = 1, and the pending ratio is never applied.
